// File: rtl/key_search_scheduler.sv
// key_search_scheduler: hands RC4 keys 0..KEY_MAX in increasing order to NUM_CORES
// decryption cores, pulses each core's reset/new-key lines, collects done/ok verdicts,
// aborts every core on the first good key and flags exhaustion when the space runs out.
// Optional build macro KEY_SEARCH_STATS_EN adds the keys_tried bad-completion counter port.
module key_search_scheduler #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_key_ok,
    output logic [NUM_CORES-1:0]           core_reset,
    output logic [NUM_CORES-1:0]           core_key_valid,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key
`ifdef KEY_SEARCH_STATS_EN
    ,
    output logic [KEY_WIDTH:0]             keys_tried
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_EXHAUSTED} top_state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_LAUNCH, SLOT_BUSY} slot_state_t;

    top_state_t                          state, state_nxt;
    slot_state_t                         slot_st [NUM_CORES];
    logic [NUM_CORES-1:0][KEY_WIDTH-1:0] slot_key;
    // One bit wider than a key so KEY_MAX = all ones terminates instead of wrapping.
    logic [KEY_WIDTH:0]                  next_key;
    logic                                abort_pulse;
    logic [NUM_CORES-1:0]                key_valid;

    logic [NUM_CORES-1:0] free_vec, launch_vec, good_vec, bad_vec;
    logic                 any_free, all_free, keys_left, abort, restart, launch;
    int                   grant_idx;
    logic [KEY_WIDTH-1:0] win_key;
    logic [KEY_WIDTH:0]   grant_key;

    // Per-slot status decode; done is only meaningful once the slot is BUSY.
    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_slot
            assign free_vec[g]   = (slot_st[g] == SLOT_FREE);
            assign launch_vec[g] = (slot_st[g] == SLOT_LAUNCH);
            assign good_vec[g]   = (slot_st[g] == SLOT_BUSY) && core_done[g] && core_key_ok[g];
            assign bad_vec[g]    = (slot_st[g] == SLOT_BUSY) && core_done[g] && !core_key_ok[g];
        end
    endgenerate

    assign all_free  = &free_vec;
    assign keys_left = (next_key <= {1'b0, KEY_MAX});
    assign abort     = (state == S_RUN) && (|good_vec);
    assign restart   = start && (state != S_RUN);
    // A restart always grants key 0, whatever the counter held from the last search.
    assign grant_key = restart ? '0 : next_key;

    assign busy           = (state == S_RUN);
    assign core_reset     = {NUM_CORES{abort_pulse}} | launch_vec;
    assign core_key_valid = key_valid;
    assign core_key       = slot_key;

    // Lowest free slot receives the grant; lowest good slot wins a tie.
    always_comb begin
        grant_idx = 0;
        any_free  = 1'b0;
        win_key   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                grant_idx = i;
                any_free  = 1'b1;
            end
            if (good_vec[i]) win_key = slot_key[i];
        end
    end

    // Top-level next state and grant decision; a good result beats exhaustion.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            S_RUN: begin
                if (abort)                       state_nxt = S_FOUND;
                else if (!keys_left && all_free) state_nxt = S_EXHAUSTED;
                else                             launch = keys_left && any_free;
            end
            default: begin
                if (start) begin
                    state_nxt = S_RUN;
                    launch    = 1'b1;
                end
            end
        endcase
    end

    // Top-level state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Key counter, result flags and per-slot FREE -> LAUNCH -> BUSY sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_key    <= '0;
            abort_pulse <= 1'b1;
            key_valid   <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_key   <= '0;
            slot_key    <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot_st[i] <= SLOT_FREE;
        end else begin
            abort_pulse <= abort;
            if (launch) next_key <= grant_key + (KEY_WIDTH+1)'(1);
            if (restart) begin
                found     <= 1'b0;
                exhausted <= 1'b0;
            end
            if (abort) begin
                found     <= 1'b1;
                found_key <= win_key;
            end
            if ((state == S_RUN) && (state_nxt == S_EXHAUSTED)) exhausted <= 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                key_valid[i] <= 1'b0;
                case (slot_st[i])
                    SLOT_FREE: begin
                        if (launch && (grant_idx == i)) begin
                            slot_st[i]  <= SLOT_LAUNCH;
                            slot_key[i] <= grant_key[KEY_WIDTH-1:0];
                        end
                    end
                    SLOT_LAUNCH: begin
                        if (abort) begin
                            slot_st[i] <= SLOT_FREE;
                        end else begin
                            slot_st[i]   <= SLOT_BUSY;
                            key_valid[i] <= 1'b1;
                        end
                    end
                    default: begin
                        if (abort || bad_vec[i]) slot_st[i] <= SLOT_FREE;
                    end
                endcase
            end
        end
    end

`ifdef KEY_SEARCH_STATS_EN
    logic [KEY_WIDTH:0] bad_cnt;

    // Number of bad completions landing this cycle.
    always_comb begin
        bad_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) bad_cnt = bad_cnt + (KEY_WIDTH+1)'(bad_vec[i]);
    end

    // Bad-key completion counter; frozen once the search has ended.
    always_ff @(posedge clk) begin
        if (reset || restart)               keys_tried <= '0;
        else if ((state == S_RUN) && !abort) keys_tried <= keys_tried + bad_cnt;
    end
`endif

endmodule

// File: tb/tb_key_search_scheduler.sv
// tb_key_search_scheduler: directed sequence with randomized core latencies and good keys.
// Core models answer each launched key; a log of issued keys is compared against the
// expected 0,1,2,... sequence for the search space KMAX.
module tb_key_search_scheduler;
    localparam int            NC    = 4;
    localparam int            KW    = 24;
    localparam logic [KW-1:0] KMAX  = 24'h00003F;
    localparam int            NKEYS = 64;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [NC-1:0]     core_done, core_key_ok, core_reset, core_key_valid;
    logic [NC*KW-1:0]  core_key;
    logic              busy, found, exhausted;
    logic [KW-1:0]     found_key;
`ifdef KEY_SEARCH_STATS_EN
    logic [KW:0]       keys_tried;
`endif

    logic [NC-1:0] done_r = '0, ok_r = '0, extra_done = '0, extra_ok = '0;
    bit   [NC-1:0] run = '0;
    int            cnt [NC];
    logic [KW-1:0] ckey [NC];
    int            lat [NC];
    bit            fixed_lat = 1'b0;
    bit            good_map [NKEYS];
    logic [KW-1:0] issued [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    assign core_done   = done_r | extra_done;
    assign core_key_ok = ok_r | extra_ok;

    key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KMAX)) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_done(core_done), .core_key_ok(core_key_ok),
        .core_reset(core_reset), .core_key_valid(core_key_valid), .core_key(core_key),
        .busy(busy), .found(found), .exhausted(exhausted), .found_key(found_key)
`ifdef KEY_SEARCH_STATS_EN
        , .keys_tried(keys_tried)
`endif
    );

    // Core models: cleared by core_reset, count down a latency after a new key, then
    // raise done (held) with ok set when the key is in the good set.
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (core_reset[i] === 1'b1) begin
                run[i]    <= 1'b0;
                done_r[i] <= 1'b0;
                ok_r[i]   <= 1'b0;
            end else if (core_key_valid[i] === 1'b1) begin
                run[i]  <= 1'b1;
                ckey[i] <= core_key[i*KW +: KW];
                cnt[i]  <= fixed_lat ? lat[i] : int'($urandom_range(30, 3));
            end else if (run[i]) begin
                if (cnt[i] <= 1) begin
                    run[i]    <= 1'b0;
                    done_r[i] <= 1'b1;
                    ok_r[i]   <= good_map[ckey[i][5:0]];
                end else begin
                    cnt[i] <= cnt[i] - 1;
                end
            end
        end
    end

    // Log every key handed to a core, in issue order.
    always @(negedge clk)
        if (reset === 1'b0)
            for (int i = 0; i < NC; i++)
                if (core_key_valid[i] === 1'b1) issued.push_back(core_key[i*KW +: KW]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] slot_key(input int i);
        return core_key[i*KW +: KW];
    endfunction

    task automatic set_good(input int a, input int b);
        for (int k = 0; k < NKEYS; k++) good_map[k] = (k == a) || (k == b);
    endtask

    // Keys since base must be 0,1,2,... with no repeats; full search covers all NKEYS.
    task automatic chk_issued(input int base, input bit full);
        for (int k = base; k < issued.size(); k++)
            chk("key_order", 64'(issued[k]), 64'(k - base));
        if (full) chk("key_count", 64'(issued.size() - base), 64'(NKEYS));
        else      chk("key_count_max", 64'((issued.size() - base) <= NKEYS), 64'd1);
    endtask

    task automatic wait_found(input int budget);
        for (int c = 0; c < budget && found !== 1'b1; c++) tick();
        chk("found_within_budget", 64'(found), 64'd1);
    endtask

    task automatic wait_exhausted(input int budget);
        for (int c = 0; c < budget && exhausted !== 1'b1; c++) tick();
        chk("exhausted_within_budget", 64'(exhausted), 64'd1);
    endtask

    initial begin
        int base;
        int n;
        int g;
        set_good(-1, -1);
        lat = '{20, 20, 20, 20};

        // Power-up reset values.
        reset = 1'b1;
        tick();
        tick();
        chk("rst_core_reset", 64'(core_reset), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_exhausted", 64'(exhausted), 64'd0);
        chk("rst_found_key", 64'(found_key), 64'd0);
        chk("rst_core_key", 64'(core_key), 64'd0);
        chk("rst_valid", 64'(core_key_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_pulse_one_cycle", 64'(core_reset), 64'd0);

        // Launch latency, then the single good key 9 with fixed latency 20.
        set_good(9, -1);
        fixed_lat = 1'b1;
        base = issued.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("n1_core_reset", 64'(core_reset), 64'b0001);
        chk("n1_busy", 64'(busy), 64'd1);
        chk("n1_key0", 64'(slot_key(0)), 64'd0);
        tick();
        chk("n2_valid", 64'(core_key_valid), 64'b0001);
        chk("n2_core_reset", 64'(core_reset), 64'b0010);
        chk("n2_key1", 64'(slot_key(1)), 64'd1);
        tick();
        chk("n3_valid", 64'(core_key_valid), 64'b0010);
        chk("n3_core_reset", 64'(core_reset), 64'b0100);
        chk("n3_key2", 64'(slot_key(2)), 64'd2);
        tick();
        chk("n4_valid", 64'(core_key_valid), 64'b0100);
        chk("n4_core_reset", 64'(core_reset), 64'b1000);
        chk("n4_key3", 64'(slot_key(3)), 64'd3);
        tick();
        chk("n5_valid", 64'(core_key_valid), 64'b1000);
        chk("n5_core_reset", 64'(core_reset), 64'd0);
        wait_found(1000);
        chk("good9_found_key", 64'(found_key), 64'd9);
        chk("good9_abort", 64'(core_reset), 64'hF);
        chk("good9_busy", 64'(busy), 64'd0);
        chk("good9_exhausted", 64'(exhausted), 64'd0);
        tick();
        chk("good9_abort_one_cycle", 64'(core_reset), 64'd0);
        n = issued.size();
        repeat (30) tick();
        chk("good9_no_valid_after", 64'(issued.size()), 64'(n));
        chk("good9_found_sticky", 64'(found), 64'd1);
        chk_issued(base, 1'b0);

        // Slots 1 and 3 report good in the same cycle: slot 1 (key 1) wins.
        set_good(1, 3);
        lat = '{40, 22, 40, 20};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tie_found_cleared", 64'(found), 64'd0);
        wait_found(500);
        chk("tie_found_key", 64'(found_key), 64'd1);

        // Reset mid-search once keys 0..40 are out.
        set_good(-1, -1);
        fixed_lat = 1'b0;
        base = issued.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2000 && (issued.size() - base) < 41; c++) tick();
        chk("midrst_keys_issued", 64'((issued.size() - base) >= 41), 64'd1);
        reset = 1'b1;
        tick();
        chk("midrst_core_reset", 64'(core_reset), 64'hF);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_found", 64'(found), 64'd0);
        chk("midrst_found_key", 64'(found_key), 64'd0);
        chk("midrst_core_key", 64'(core_key), 64'd0);
        chk("midrst_valid", 64'(core_key_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("midrst_pulse_end", 64'(core_reset), 64'd0);

        // Restart from key 0, ignore a start while running, run to exhaustion.
        base = issued.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_reset0", 64'(core_reset), 64'b0001);
        chk("restart_key0", 64'(slot_key(0)), 64'd0);
        tick();
        chk("restart_valid0", 64'(core_key_valid), 64'b0001);
        repeat (40) tick();
        chk("busy_before_extra_start", 64'(busy), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_extra_start", 64'(busy), 64'd1);
        wait_exhausted(4000);
        chk("exh_found", 64'(found), 64'd0);
        chk("exh_busy", 64'(busy), 64'd0);
        chk_issued(base, 1'b1);
`ifdef KEY_SEARCH_STATS_EN
        chk("exh_keys_tried", 64'(keys_tried), 64'(NKEYS));
`endif

        // done/ok held on free slots after exhaustion changes nothing.
        extra_done = '1;
        extra_ok   = '1;
        n = issued.size();
        repeat (10) tick();
        chk("free_done_exhausted", 64'(exhausted), 64'd1);
        chk("free_done_found", 64'(found), 64'd0);
        chk("free_done_no_valid", 64'(issued.size()), 64'(n));
        chk("free_done_core_reset", 64'(core_reset), 64'd0);
`ifdef KEY_SEARCH_STATS_EN
        chk("free_done_keys_tried", 64'(keys_tried), 64'(NKEYS));
`endif
        extra_done = '0;
        extra_ok   = '0;
        tick();

        // Random good key with random core latencies.
        repeat (3) begin
            g = int'($urandom_range(60, 10));
            set_good(g, -1);
            base = issued.size();
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("rnd_exhausted_cleared", 64'(exhausted), 64'd0);
            chk("rnd_busy", 64'(busy), 64'd1);
`ifdef KEY_SEARCH_STATS_EN
            chk("rnd_keys_tried_zero", 64'(keys_tried), 64'd0);
`endif
            wait_found(3000);
            chk("rnd_found_key", 64'(found_key), 64'(g));
            chk("rnd_exhausted", 64'(exhausted), 64'd0);
            chk_issued(base, 1'b0);
            tick();
        end

        chk("found_exhausted_exclusive", 64'(found & exhausted), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
